// File: rtl/laser_frame_receiver.sv
// Laser frame receiver: recovers 8N1 asynchronous byte frames from the
// photodiode line, with majority-voted sampling, framing-error reporting and
// byte/error counters for the HEX displays.
module laser_frame_receiver #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter bit          RX_INVERT    = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        en,
   input  logic        laser_rx,
   output logic        data_valid,
   output logic [7:0]  data_in,
   output logic        frame_error,
   output logic        busy,
   output logic [15:0] byte_count,
   output logic [7:0]  err_count
);

   localparam int unsigned HALF = CLKS_PER_BIT / 2;
   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitIdle
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    sync_q;
   logic [2:0]    hist_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_in_q, data_in_d;
   logic          data_valid_q, data_valid_d;
   logic          frame_error_q, frame_error_d;
   logic [15:0]   byte_count_q;
   logic [7:0]    err_count_q;
   logic          rx_s;
   logic          maj;

   assign rx_s = sync_q[1] ^ RX_INVERT;
   assign maj  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

   // Synchroniser and majority history; both idle high so reset looks like a quiet line
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
         hist_q <= 3'b111;
      end else begin
         sync_q <= {sync_q[0], laser_rx};
         hist_q <= {hist_q[1:0], rx_s};
      end
   end

   // Frame FSM next-state: cnt_q times half-bit/bit intervals, and counts idle cycles in StWaitIdle
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      data_in_d     = data_in_q;
      data_valid_d  = 1'b0;
      frame_error_d = 1'b0;
      if (!en) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!rx_s) begin
                  state_d = StStart;
                  cnt_d   = '0;
               end
            end
            StStart: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_d = '0;
                  if (maj) begin
                     state_d = StIdle;
                  end else begin
                     state_d   = StData;
                     bit_idx_d = '0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StData: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_d   = '0;
                  shift_d = {maj, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) begin
                     state_d = StStop;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StStop: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_d = '0;
                  if (maj) begin
                     data_valid_d = 1'b1;
                     data_in_d    = shift_q;
                     state_d      = StIdle;
                  end else begin
                     frame_error_d = 1'b1;
                     state_d       = StWaitIdle;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StWaitIdle: begin
               // A held-low break must see a full bit time of idle before re-arming
               if (rx_s) begin
                  if (cnt_q == BIT_LAST) begin
                     state_d = StIdle;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Frame FSM state and registered output pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         data_in_q     <= '0;
         data_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         data_in_q     <= data_in_d;
         data_valid_q  <= data_valid_d;
         frame_error_q <= frame_error_d;
      end
   end

   // Good-byte counter wraps; error counter saturates
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         byte_count_q <= '0;
         err_count_q  <= '0;
      end else begin
         if (data_valid_d) byte_count_q <= byte_count_q + 16'd1;
         if (frame_error_d && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
      end
   end

   assign data_valid  = data_valid_q;
   assign data_in     = data_in_q;
   assign frame_error = frame_error_q;
   assign busy        = (state_q != StIdle);
   assign byte_count  = byte_count_q;
   assign err_count   = err_count_q;

endmodule
